// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run-control sequencer.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    SETTLE,
    RUN,
    HALT,
    STEP
  } run_state_t;

  localparam int CLEAR_CYCLES_DEF = 4;
  localparam int WDOG_CYCLES_DEF  = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count compare.
module hold_counter
  import core_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/core_run_controller.sv
// Run-control sequencer: reset hold, settle, run, halt and single-step.
// Optional watchdog (heartbeat/wdog_trip ports) enabled by `define CORE_WDOG_EN.
module core_run_controller
  import core_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter bit BOOT_HALT    = 1'b0,
  parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
`ifdef CORE_WDOG_EN
  input  logic heartbeat,
  output logic wdog_trip,
`endif
  input  logic soft_rst_req,
  input  logic halt_req,
  input  logic resume_req,
  input  logic step_req,
  output logic enable,
  output logic clear_pc,
  output logic halted,
  output logic step_done
);

  localparam int CNT_W = $clog2(max_int(CLEAR_CYCLES, WDOG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  run_state_t state, next_state;
  logic       clear_tc;
  logic       wdog_fire;

  // Counts only while in CLEAR; zeroed on leaving CLEAR so every entry starts fresh.
  hold_counter #(.WIDTH(CNT_W)) u_clear_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (soft_rst_req || (next_state != CLEAR)),
    .en       (state == CLEAR),
    .terminal (CLEAR_LAST),
    .tc       (clear_tc)
  );

`ifdef CORE_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
  logic wdog_tc;

  hold_counter #(.WIDTH(CNT_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (heartbeat || (next_state != RUN)),
    .en       (state == RUN),
    .terminal (WDOG_LAST),
    .tc       (wdog_tc)
  );

  assign wdog_fire = (state == RUN) && wdog_tc && !heartbeat;
`else
  assign wdog_fire = 1'b0;
`endif

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clear_tc) next_state = SETTLE;
      SETTLE:  next_state = BOOT_HALT ? HALT : RUN;
      RUN: begin
        if (wdog_fire)     next_state = CLEAR;
        else if (halt_req) next_state = HALT;
      end
      HALT: begin
        // halt_req outranks resume/step, so it pins the block in HALT.
        if (halt_req)        next_state = HALT;
        else if (resume_req) next_state = RUN;
        else if (step_req)   next_state = STEP;
      end
      STEP:    next_state = HALT;
      default: next_state = CLEAR;
    endcase
    if (soft_rst_req) next_state = CLEAR;
  end

  // Outputs are decoded from next_state so they are flops aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      enable    <= 1'b0;
      clear_pc  <= 1'b1;
      halted    <= 1'b0;
      step_done <= 1'b0;
`ifdef CORE_WDOG_EN
      wdog_trip <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      enable    <= (next_state == RUN) || (next_state == STEP);
      clear_pc  <= (next_state == CLEAR);
      halted    <= (next_state == HALT);
      step_done <= (state == STEP) && (next_state == HALT);
`ifdef CORE_WDOG_EN
      wdog_trip <= wdog_fire && !soft_rst_req;
`endif
    end
  end

endmodule
